// File: rtl/user_module_stim_if.sv
// Host-side command/response channel for user_module_stim.
// master = host, slave = stimulus engine.
interface user_module_stim_if #(
    parameter int CNT_W = 8,
    parameter int DIV_W = 8
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [6:0]       cmd_data;
    logic [CNT_W-1:0] cmd_cycles;
    logic [DIV_W-1:0] div;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [7:0]       rsp_data;

    modport master (output cmd_valid, cmd_data, cmd_cycles, div, rsp_ready,
                    input  cmd_ready, rsp_valid, rsp_data);
    modport slave  (input  cmd_valid, cmd_data, cmd_cycles, div, rsp_ready,
                    output cmd_ready, rsp_valid, rsp_data);
endinterface

// File: rtl/user_module_stim.sv
// Drives a pattern plus N slow clock pulses into a user module's io_in and returns io_out.
// Optional USER_STIM_IOOUT_SYNC_EN: 2-flop synchronizer on io_out, 3-cycle capture.
module user_module_stim #(
    parameter int CNT_W     = 8,
    parameter int DIV_W     = 8,
    parameter int SETUP_CYC = 2
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    user_module_stim_if.slave    bus,
    output logic                 busy,
    output logic [7:0]           io_in,
    input  logic [7:0]           io_out
);
    localparam int SW     = $clog2(SETUP_CYC + 1) + 1;
    localparam int TW0    = (DIV_W > SW) ? DIV_W : SW;
    localparam int TMR_W  = (TW0 > 2) ? TW0 : 2;
`ifdef USER_STIM_IOOUT_SYNC_EN
    localparam int CAP_CYC = 3;
`else
    localparam int CAP_CYC = 1;
`endif

    typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, CAPTURE, RESP} state_t;

    state_t           state_q, state_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic [DIV_W-1:0] d_q, d_d;
    logic [7:0]       io_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [7:0]       rsp_data_q, rsp_data_d;
    logic [7:0]       cap_src;

`ifdef USER_STIM_IOOUT_SYNC_EN
    logic [7:0] sync1_q, sync2_q;
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            sync1_q <= 8'h00;
            sync2_q <= 8'h00;
        end else begin
            sync1_q <= io_out;
            sync2_q <= sync1_q;
        end
    end
    assign cap_src = sync2_q;
`else
    assign cap_src = io_out;
`endif

    assign bus.cmd_ready = (state_q == IDLE);
    assign busy          = (state_q != IDLE);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q     <= IDLE;
            tmr_q       <= '0;
            rem_q       <= '0;
            d_q         <= '0;
            io_in       <= 8'h00;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 8'h00;
        end else begin
            state_q     <= state_d;
            tmr_q       <= tmr_d;
            rem_q       <= rem_d;
            d_q         <= d_d;
            io_in       <= io_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    // tmr counts down the remaining cycles of the current phase; 0 means last cycle.
    always_comb begin
        state_d     = state_q;
        tmr_d       = tmr_q;
        rem_d       = rem_q;
        d_d         = d_q;
        io_d        = io_in;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        case (state_q)
            IDLE: begin
                if (bus.cmd_valid) begin
                    rem_d   = bus.cmd_cycles;
                    d_d     = (bus.div == '0) ? DIV_W'(1) : bus.div;
                    io_d    = {bus.cmd_data, 1'b0};
                    tmr_d   = TMR_W'(SETUP_CYC - 1);
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (tmr_q != '0) begin
                    tmr_d = tmr_q - TMR_W'(1);
                end else if (rem_q != '0) begin
                    io_d[0] = 1'b1;
                    tmr_d   = TMR_W'(d_q) - TMR_W'(1);
                    state_d = HIGH;
                end else begin
                    tmr_d   = TMR_W'(CAP_CYC - 1);
                    state_d = CAPTURE;
                end
            end
            HIGH: begin
                if (tmr_q != '0) begin
                    tmr_d = tmr_q - TMR_W'(1);
                end else begin
                    io_d[0] = 1'b0;
                    rem_d   = rem_q - CNT_W'(1);
                    tmr_d   = TMR_W'(d_q) - TMR_W'(1);
                    state_d = LOW;
                end
            end
            LOW: begin
                if (tmr_q != '0) begin
                    tmr_d = tmr_q - TMR_W'(1);
                end else if (rem_q != '0) begin
                    io_d[0] = 1'b1;
                    tmr_d   = TMR_W'(d_q) - TMR_W'(1);
                    state_d = HIGH;
                end else begin
                    tmr_d   = TMR_W'(CAP_CYC - 1);
                    state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                if (tmr_q != '0) begin
                    tmr_d = tmr_q - TMR_W'(1);
                end else begin
                    rsp_data_d  = cap_src;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_user_module_stim.sv
// Randomized directed bench for user_module_stim against a cycle-position waveform model.
module tb_user_module_stim;
    localparam int S = 2;
`ifdef USER_STIM_IOOUT_SYNC_EN
    localparam int EXTRA = 2;
`else
    localparam int EXTRA = 0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       busy;
    logic [7:0] io_in;
    logic [7:0] io_out;
    int         pass_cnt = 0;
    int         total_cnt = 0;

    user_module_stim_if #(.CNT_W(8), .DIV_W(8)) bus ();

    user_module_stim #(.CNT_W(8), .DIV_W(8), .SETUP_CYC(S)) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .bus      (bus),
        .busy     (busy),
        .io_in    (io_in),
        .io_out   (io_out)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Expected io_in[0] in the n-th cycle after the command handshake:
    // S setup cycles, then C periods of D high + D low, then low forever.
    function automatic bit exp_io0(input int n, input int c, input int d);
        int p = n - S - 1;
        if (p < 0 || p >= 2 * c * d) return 1'b0;
        return (p % (2 * d)) < d;
    endfunction

    task automatic start_cmd(input logic [6:0] data, input int cyc, input int dv,
                             input logic [7:0] oo, input bit rdy);
        int w = 0;
        while (!bus.cmd_ready && w < 1000) begin
            @(negedge clk);
            w++;
        end
        check("idle_before_cmd", bus.cmd_ready, 1);
        io_out         = oo;
        bus.cmd_data   = data;
        bus.cmd_cycles = cyc[7:0];
        bus.div        = dv[7:0];
        bus.rsp_ready  = rdy;
        bus.cmd_valid  = 1'b1;
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
    endtask

    task automatic run_cmd(input logic [6:0] data, input int cyc, input int dv,
                           input logic [7:0] oo, input int hold);
        int d = (dv == 0) ? 1 : dv;
        int lat = S + 2 + 2 * cyc * d + EXTRA;
        int n = 0, rises = 0, werr = 0, chg = 0;
        bit prev = 1'b0, got = 1'b0;
        start_cmd(data, cyc, dv, oo, hold == 0);
        while (!got && n < lat + 20) begin
            @(negedge clk);
            n++;
            if (io_in[0] !== exp_io0(n, cyc, d)) werr++;
            if (io_in[7:1] !== data) werr++;
            if (io_in[0] && !prev) rises++;
            prev = io_in[0];
            if (bus.rsp_valid) got = 1'b1;
        end
        check("latency", n, lat);
        check("waveform", werr, 0);
        check("rises", rises, cyc);
        check("rsp_data", bus.rsp_data, oo);
        if (hold > 0) begin
            bus.cmd_valid  = 1'b1;
            bus.cmd_data   = ~data;
            bus.cmd_cycles = 8'd1;
            for (int k = 0; k < hold; k++) begin
                @(negedge clk);
                if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== oo) chg++;
                if (bus.cmd_ready !== 1'b0 || io_in !== {data, 1'b0}) chg++;
            end
            check("resp_hold_stable", chg, 0);
            bus.cmd_valid = 1'b0;
            bus.rsp_ready = 1'b1;
        end
        @(negedge clk);
        check("rsp_cleared", bus.rsp_valid, 0);
        check("idle_after", busy, 0);
        check("io_in_final", io_in, {data, 1'b0});
    endtask

    initial begin
        rst = 1'b0;
        io_out = 8'h00;
        bus.cmd_valid = 1'b0;
        bus.cmd_data = '0;
        bus.cmd_cycles = '0;
        bus.div = '0;
        bus.rsp_ready = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("rst_io_in", io_in, 8'h00);
        check("rst_rsp_valid", bus.rsp_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_cmd_ready", bus.cmd_ready, 1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("post_rst_io_in", io_in, 8'h00);
        check("post_rst_busy", busy, 0);
        check("post_rst_rsp", bus.rsp_valid, 0);
        check("post_rst_ready", bus.cmd_ready, 1);

        run_cmd(7'h55, 0, 3, 8'h3C, 0);
        run_cmd(7'h12, 3, 2, 8'hA5, 0);
        run_cmd(7'h7F, 2, 0, 8'h81, 0);
        run_cmd(7'h33, 1, 1, 8'h5A, 10);

        // Reset in the middle of the second high phase of a 4-pulse command.
        start_cmd(7'h29, 4, 3, 8'hEE, 1'b1);
        repeat (S + 2 * 3 + 2) @(negedge clk);
        check("mid_high_before_rst", io_in, {7'h29, 1'b1});
        rst = 1'b1;
        #1;
        check("midrst_io_in", io_in, 8'h00);
        check("midrst_busy", busy, 0);
        check("midrst_rsp", bus.rsp_valid, 0);
        check("midrst_ready", bus.cmd_ready, 1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_cmd(7'h0F, 2, 2, 8'h66, 0);

        for (int i = 0; i < 6; i++) begin
            run_cmd(7'($urandom), int'($urandom_range(0, 5)), int'($urandom_range(0, 4)),
                    8'($urandom), int'($urandom_range(0, 3)));
        end
        run_cmd(7'h41, 255, 1, 8'hC3, 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
